word_receiver: RTL and testbench
================================

Name: word_receiver

Overview:
- Parametrised serial-to-parallel receiver for the I2C peripheral datapath; successor to the fixed 8-bit shift stage.
- Shifts in one bit per qualified strobe, counts bits internally, and frames complete words.
- Completed words are presented on a valid/ready holding register, with overrun detection.
- Sits between the bus bit-sampler (SCL-edge strobe, SDA value) and the register/command decoder.

Parameters:
- WIDTH, 8, data bits per word (≥2)
- MSB_FIRST, 1, 1 = first received bit lands in out[WIDTH-1]; 0 = first received bit lands in out[0]

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- enable  input  1  receive window; low aborts and clears any partial word
- bit_valid  input  1  one-cycle strobe: sample `in` this cycle
- in  input  1  serial data bit
- word_ready  input  1  consumer accepts the held word
- overrun_clr  input  1  clears the sticky overrun flag
- out  output  WIDTH  held completed word
- word_valid  output  1  out holds an unconsumed word
- overrun  output  1  sticky: a word completed while the previous word was unconsumed
- shift_out  output  WIDTH  live partial shift register (debug/early peek)
- bit_count  output  $clog2(WIDTH+2)  bits received in the current frame

Behaviour:
- Reset (synchronous, active-high, one clock, clk): all outputs and internal state go to 0.
- enable=0: shift register and bit_count cleared next edge. out, word_valid and overrun are unaffected; word_ready and overrun_clr are still honoured.
- Shifting on enable=1 & bit_valid=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], in}.
  - MSB_FIRST=0: sr <= {in, sr[WIDTH-1:1]}.
  - bit_count increments.
- enable=1 & bit_valid=0: hold state.
- Frame completion: a strobe arrives with bit_count == FRAME-1 (FRAME = WIDTH, or WIDTH+1 with parity). On that edge:
  - out <= assembled word, including the final bit.
  - word_valid <= 1.
  - sr <= 0, bit_count <= 0.
  - Latency: word_valid is high in the cycle after the final strobe.
- Back-to-back frames: reception continues immediately; no idle bit is required between words.
- Handshake: word_valid & word_ready at an edge clears word_valid, unless a completion occurs on the same edge. In that case the new word loads, word_valid stays 1, and overrun is not set.
- Completion while word_valid=1 and word_ready=0:
  - out is overwritten (newest word wins).
  - word_valid stays 1.
  - overrun <= 1.
- overrun clears only on overrun_clr or reset. Simultaneous set and clear: set wins.
- enable falling mid-frame: partial bits are discarded, and no word_valid or overrun results.
- bit_count never exceeds FRAME-1 when observed between edges.

Optional Feature:
- Macro: WORD_RECEIVER_PARITY_EN.
- Defined:
  - FRAME = WIDTH+1; the last bit is an even-parity bit and is not shifted into sr.
  - Extra output port parity_err (1 bit), updated on every completion: parity_err <= ^{word, parity_bit}. It is 0 for a good frame and is held until the next completion or reset.
  - shift_out shows data bits only.
- Undefined: FRAME = WIDTH, no parity_err port, and no parity logic is synthesised.

Decomposition:
- Shared package i2c_rx_pkg (used by the sampler and decoder):
  - bit-order constants RX_MSB_FIRST=1 and RX_LSB_FIRST=0
  - default word width constant RX_WORD_W=8
  - function for the bit_count width
- One natural sub-module, rx_shift_stage: parametrised shift register plus bit counter, emitting a frame_done pulse and the assembled word.
- word_receiver wraps rx_shift_stage with the holding register, handshake, overrun logic and parity.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, enable=1; strobe bits 1,0,1,0,0,1,0,1 → out=8'hA5, word_valid=1 one cycle after the 8th strobe, bit_count=0, overrun=0.
2. MSB_FIRST=0, same bit stream → out=8'hA5 reversed = 8'hA5 is a palindrome, so use 1,1,0,0,0,0,0,0 → out=8'h03; with MSB_FIRST=1 the same stream gives 8'hC0.
3. Receive 8'h3C with word_ready=0, then 8'h81 without asserting ready → out=8'h81, word_valid=1, overrun=1. Pulse overrun_clr → overrun=0, word_valid still 1.
4. Assert word_ready on the same cycle as the 8th strobe of a second word (first word still valid) → out=new word, word_valid=1, overrun=0.
5. Strobe 5 bits, drop enable for 1 cycle, re-enable, strobe 8 bits of 8'h5A → out=8'h5A; no word_valid before the 8th strobe; bit_count reads 0 after enable drop.
6. With WORD_RECEIVER_PARITY_EN: frame 8'hA5 + parity 0 → parity_err=0; frame 8'hA5 + parity 1 → parity_err=1. Mid-frame reset → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/word_receiver_pkg.sv
// Shared receive-path definitions for the I2C sampler, word receiver and decoder.
package i2c_rx_pkg;

  localparam int RX_MSB_FIRST = 1;
  localparam int RX_LSB_FIRST = 0;
  localparam int RX_WORD_W    = 8;

  // Counter must hold 0..WIDTH (parity frames run one bit past the data).
  function automatic int rx_count_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/rx_shift_stage.sv
// Serial-in shift register with frame bit counter; pulses frame_done on the
// strobe that completes a frame and presents the assembled data word.
module rx_shift_stage import i2c_rx_pkg::*; #(
  parameter  int WIDTH     = RX_WORD_W,
  parameter  int MSB_FIRST = RX_MSB_FIRST,
  parameter  int FRAME     = WIDTH,
  localparam int CW        = rx_count_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bit_valid,
  input  logic             in,
  output logic [WIDTH-1:0] shift_out,
  output logic [CW-1:0]    bit_count,
  output logic             frame_done,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             last_bit;

  always_comb begin
    if (MSB_FIRST == RX_MSB_FIRST) sr_next = {sr[WIDTH-2:0], in};
    else                           sr_next = {in, sr[WIDTH-1:1]};
    last_bit   = (bit_count == CW'(FRAME - 1));
    frame_done = enable & bit_valid & last_bit;
    // With a trailing parity bit the data is already complete in sr.
    word       = (FRAME == WIDTH) ? sr_next : sr;
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (bit_valid) begin
      if (last_bit) begin
        sr        <= '0;
        bit_count <= '0;
      end else begin
        sr        <= sr_next;
        bit_count <= bit_count + 1'b1;
      end
    end
  end

  assign shift_out = sr;

endmodule

// File: rtl/word_receiver.sv
// Serial-to-parallel word receiver with valid/ready holding register and
// sticky overrun. Define WORD_RECEIVER_PARITY_EN for a trailing even-parity bit.
module word_receiver import i2c_rx_pkg::*; #(
  parameter  int WIDTH     = RX_WORD_W,
  parameter  int MSB_FIRST = RX_MSB_FIRST,
  localparam int CW        = rx_count_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bit_valid,
  input  logic             in,
  input  logic             word_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] out,
  output logic             word_valid,
  output logic             overrun,
  output logic [WIDTH-1:0] shift_out,
  output logic [CW-1:0]    bit_count
`ifdef WORD_RECEIVER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef WORD_RECEIVER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             frame_done;
  logic [WIDTH-1:0] word;

  rx_shift_stage #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .FRAME     (FRAME)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bit_valid  (bit_valid),
    .in         (in),
    .shift_out  (shift_out),
    .bit_count  (bit_count),
    .frame_done (frame_done),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // A completion on the accepting edge replaces the word without overrun.
      if (frame_done) begin
        out        <= word;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      if (frame_done && word_valid && !word_ready) overrun <= 1'b1;
      else if (overrun_clr)                        overrun <= 1'b0;
    end
  end

`ifdef WORD_RECEIVER_PARITY_EN
  // On the completing strobe `in` carries the parity bit.
  always_ff @(posedge clk) begin
    if (reset)           parity_err <= 1'b0;
    else if (frame_done) parity_err <= ^{word, in};
  end
`endif

endmodule

// File: tb/tb_word_receiver.sv
// Directed bench for word_receiver: MSB-first and LSB-first instances share
// stimulus; parity checks compile in with WORD_RECEIVER_PARITY_EN.
module tb_word_receiver;
  import i2c_rx_pkg::*;

  logic       clk = 1'b0;
  logic       reset, enable, bit_valid, in_bit, word_ready, overrun_clr;
  logic [7:0] out_m, out_l, sh_m, sh_l;
  logic       valid_m, valid_l, ovr_m, ovr_l;
  logic [3:0] cnt_m, cnt_l;
`ifdef WORD_RECEIVER_PARITY_EN
  logic       perr_m, perr_l;
  logic       parity_flip = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  word_receiver #(.WIDTH(8), .MSB_FIRST(RX_MSB_FIRST)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bit_valid(bit_valid),
    .in(in_bit), .word_ready(word_ready), .overrun_clr(overrun_clr),
    .out(out_m), .word_valid(valid_m), .overrun(ovr_m),
    .shift_out(sh_m), .bit_count(cnt_m)
`ifdef WORD_RECEIVER_PARITY_EN
    , .parity_err(perr_m)
`endif
  );

  word_receiver #(.WIDTH(8), .MSB_FIRST(RX_LSB_FIRST)) dut_l (
    .clk(clk), .reset(reset), .enable(enable), .bit_valid(bit_valid),
    .in(in_bit), .word_ready(word_ready), .overrun_clr(overrun_clr),
    .out(out_l), .word_valid(valid_l), .overrun(ovr_l),
    .shift_out(sh_l), .bit_count(cnt_l)
`ifdef WORD_RECEIVER_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

  typedef struct {
    logic [7:0] stream;  // stream[7] is sent first
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input logic clr);
    enable = 1'b1; bit_valid = 1'b0; word_ready = rdy; overrun_clr = clr;
    tick;
    word_ready = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic strobe(input logic b, input logic rdy, input logic clr);
    enable = 1'b1; bit_valid = 1'b1; in_bit = b; word_ready = rdy; overrun_clr = clr;
    tick;
    bit_valid = 1'b0; in_bit = 1'b0; word_ready = 1'b0; overrun_clr = 1'b0;
  endtask

  // rdy/clr are applied on the frame-completing strobe only.
  task automatic send_word(input logic [7:0] s, input logic rdy, input logic clr);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        check("count7_m", 16'(cnt_m), 16'd7);
        check("count7_l", 16'(cnt_l), 16'd7);
      end
`ifdef WORD_RECEIVER_PARITY_EN
      strobe(s[7-i], 1'b0, 1'b0);
`else
      strobe(s[7-i], (i == 7) ? rdy : 1'b0, (i == 7) ? clr : 1'b0);
`endif
    end
`ifdef WORD_RECEIVER_PARITY_EN
    check("count8_m", 16'(cnt_m), 16'd8);
    check("sh_data_m", 16'(sh_m), 16'(s));
    strobe((^s) ^ parity_flip, rdy, clr);
`endif
  endtask

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{8'hC0, 8'hC0, 8'h03};
    tbl[2] = '{8'h12, 8'h12, 8'h48};
    tbl[3] = '{8'hF0, 8'hF0, 8'h0F};
    tbl[4] = '{8'h01, 8'h01, 8'h80};
    tbl[5] = '{8'h6B, 8'h6B, 8'hD6};
    tbl[6] = '{8'h3C, 8'h3C, 8'h3C};

    reset = 1'b1; enable = 1'b0; bit_valid = 1'b0; in_bit = 1'b0;
    word_ready = 1'b0; overrun_clr = 1'b0;
    tick; tick;
    check("rst_out_m", 16'(out_m), 16'h0);
    check("rst_valid_m", 16'(valid_m), 16'h0);
    check("rst_ovr_m", 16'(ovr_m), 16'h0);
    check("rst_cnt_m", 16'(cnt_m), 16'h0);
    check("rst_sh_l", 16'(sh_l), 16'h0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      idle(1'b1, 1'b1);
      check("pre_valid_m", 16'(valid_m), 16'h0);
      send_word(tbl[v].stream, 1'b0, 1'b0);
      check("vec_out_m", 16'(out_m), 16'(tbl[v].exp_m));
      check("vec_out_l", 16'(out_l), 16'(tbl[v].exp_l));
      check("vec_valid_m", 16'(valid_m), 16'h1);
      check("vec_valid_l", 16'(valid_l), 16'h1);
      check("vec_ovr_m", 16'(ovr_m), 16'h0);
      check("vec_cnt_m", 16'(cnt_m), 16'h0);
      check("vec_sh_m", 16'(sh_m), 16'h0);
`ifdef WORD_RECEIVER_PARITY_EN
      check("vec_perr_m", 16'(perr_m), 16'h0);
`endif
    end

    // Overrun: newest word wins, sticky flag, clear leaves word_valid.
    idle(1'b1, 1'b1);
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'h81, 1'b0, 1'b0);
    check("ovr_out_m", 16'(out_m), 16'h81);
    check("ovr_valid_m", 16'(valid_m), 16'h1);
    check("ovr_set_m", 16'(ovr_m), 16'h1);
    check("ovr_set_l", 16'(ovr_l), 16'h1);
    idle(1'b0, 1'b1);
    check("ovr_clr_m", 16'(ovr_m), 16'h0);
    check("ovr_clr_valid_m", 16'(valid_m), 16'h1);

    // Ready on the completing edge: reload, stay valid, no overrun.
    send_word(8'h12, 1'b1, 1'b0);
    check("same_edge_out_m", 16'(out_m), 16'h12);
    check("same_edge_out_l", 16'(out_l), 16'h48);
    check("same_edge_valid_m", 16'(valid_m), 16'h1);
    check("same_edge_ovr_m", 16'(ovr_m), 16'h0);
    idle(1'b1, 1'b0);
    check("accept_valid_m", 16'(valid_m), 16'h0);

    // Overrun set and clear on the same edge: set wins.
    send_word(8'hF0, 1'b0, 1'b0);
    check("f0_ovr_m", 16'(ovr_m), 16'h0);
    send_word(8'h01, 1'b0, 1'b1);
    check("setwins_ovr_m", 16'(ovr_m), 16'h1);
    check("setwins_out_l", 16'(out_l), 16'h80);

    // Enable drop mid-frame discards partial bits.
    idle(1'b1, 1'b1);
    strobe(1'b1, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0); strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0);
    check("part_cnt_m", 16'(cnt_m), 16'h5);
    check("part_sh_m", 16'(sh_m), 16'h1B);
    check("part_sh_l", 16'(sh_l), 16'hD8);
    idle(1'b0, 1'b0);
    check("hold_cnt_m", 16'(cnt_m), 16'h5);
    enable = 1'b0;
    tick;
    check("drop_cnt_m", 16'(cnt_m), 16'h0);
    check("drop_sh_m", 16'(sh_m), 16'h0);
    check("drop_valid_m", 16'(valid_m), 16'h0);
    check("drop_ovr_m", 16'(ovr_m), 16'h0);
    send_word(8'h5A, 1'b0, 1'b0);
    check("after_drop_out_m", 16'(out_m), 16'h5A);
    check("after_drop_valid_m", 16'(valid_m), 16'h1);
    strobe(1'b1, 1'b0, 1'b0); strobe(1'b0, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    tick;
    check("dis_keep_valid_m", 16'(valid_m), 16'h1);
    check("dis_keep_out_m", 16'(out_m), 16'h5A);
    check("dis_cnt_m", 16'(cnt_m), 16'h0);
    enable = 1'b0; word_ready = 1'b1;
    tick;
    word_ready = 1'b0;
    check("dis_ready_valid_m", 16'(valid_m), 16'h0);

`ifdef WORD_RECEIVER_PARITY_EN
    idle(1'b1, 1'b1);
    parity_flip = 1'b0;
    send_word(8'hA5, 1'b1, 1'b0);
    check("par_good_m", 16'(perr_m), 16'h0);
    parity_flip = 1'b1;
    send_word(8'hA5, 1'b1, 1'b0);
    check("par_bad_m", 16'(perr_m), 16'h1);
    check("par_bad_l", 16'(perr_l), 16'h1);
    idle(1'b0, 1'b0);
    check("par_hold_m", 16'(perr_m), 16'h1);
    parity_flip = 1'b0;
`endif

    // Mid-frame reset with a held word and overrun pending.
    idle(1'b1, 1'b1);
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'h81, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mrst_out_m", 16'(out_m), 16'h0);
    check("mrst_valid_m", 16'(valid_m), 16'h0);
    check("mrst_ovr_m", 16'(ovr_m), 16'h0);
    check("mrst_cnt_m", 16'(cnt_m), 16'h0);
    check("mrst_sh_m", 16'(sh_m), 16'h0);
`ifdef WORD_RECEIVER_PARITY_EN
    check("mrst_perr_m", 16'(perr_m), 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
